sc_mul_array: RTL and testbench
===============================

Name: sc_mul_array

Overview:
- Parametrised multi-channel stochastic-computing multiplier. Successor to the single-lane unipolar AND multiplier.
- Adds a selectable unipolar (AND) or bipolar (XNOR) mode, a stream-length controlled run, per-lane ones counters that give a binary estimate, and a registered nummax product per lane.
- Sits between the stochastic number generators (SNGs) and the binary readout/accumulation logic.

Parameters:
- N_CH, 4, number of independent multiplier lanes
- W, 9, width of each input nummax field
- LEN_W, 10, width of the stream-length and ones-counter fields (max stream 2^LEN_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE only)
- stream_len  in  LEN_W  number of bits per lane in the run; sampled on start
- mode  in  1  0 = unipolar (c = a & b), 1 = bipolar (c = ~(a ^ b)); sampled on start
- a_nummax  in  N_CH*W  per-lane range of operand A; sampled on start
- b_nummax  in  N_CH*W  per-lane range of operand B; sampled on start
- in_valid  in  1  a_bits/b_bits hold a valid bit this cycle
- a_bits  in  N_CH  operand A stream bit per lane
- b_bits  in  N_CH  operand B stream bit per lane
- c_bits  out  N_CH  registered product stream bits
- c_valid  out  1  c_bits valid (registered)
- newnummax  out  N_CH*2W  per-lane a_nummax*b_nummax, unsigned, full width
- ones_cnt  out  N_CH*LEN_W  per-lane count of 1s in the product stream for the current/last run
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a run completes

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. All outputs 0: c_bits, c_valid, newnummax, ones_cnt, busy, done. Bit counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, stream_len!=0 -> RUN. Same edge: latch mode and stream_len, newnummax <= a_nummax*b_nummax per lane, clear ones_cnt and bit counter.
- IDLE, start=1, stream_len==0 -> DONE directly. newnummax still latched; ones_cnt cleared.
- RUN: each cycle with in_valid=1 is an accept.
  - c_bits <= product(mode) per lane, c_valid <= 1.
  - Each lane's ones_cnt += product bit, bit counter += 1.
  - Cycles with in_valid=0: c_valid <= 0, c_bits hold, no count change.
- RUN -> DONE on the accept where bit counter == stream_len-1. ones_cnt is final at that edge.
- DONE: done=1 for exactly one cycle, then -> IDLE. in_valid is ignored in DONE and IDLE; c_valid=0 in those states.
- start while in RUN or DONE is ignored; no restart.
- busy = (state==RUN), registered.
- ones_cnt and newnummax hold after done until the next accepted start.
- ones_cnt cannot overflow, since ones <= stream_len <= 2^LEN_W-1.
- Latency: c_bits appears 1 cycle after its accept. done is high the cycle after the last accept.
- Reset mid-run aborts the run: all state and outputs return to reset values; no done pulse.

Optional Feature:
- Macro: SC_MUL_ISOLATE_EN.
- Defined: each lane inserts a 1-cycle isolator register on b to decorrelate operands.
  - Product uses a_bits with b_del. b_del <= b_bits on each accept. b_del is cleared to 0 on the accepting start.
  - Stream length and done timing are unchanged. The first product of a run uses b_del=0.
- Not defined: product uses b_bits directly; no isolator register exists.

Decomposition:
- Shared package sc_pkg holds:
  - enum sc_mode_e {SC_UNIPOLAR=0, SC_BIPOLAR=1}
  - enum sc_mul_state_e {IDLE, RUN, DONE}
  - localparam defaults SC_NUMMAX_W=9, SC_LEN_W=10
- Sub-module sc_mul_lane, instantiated N_CH times via generate. Contains the product gate, the optional isolator, the c_bits register, the ones counter and the nummax multiply register.
- Top level holds the FSM, the bit counter and the latched mode/stream_len.

Test Plan:
- Unipolar, N_CH=4, stream_len=8. Lane0 a=8'b11110000, b=8'b10101010, in_valid constant -> c stream 10100000, ones_cnt[0]=2, done 1 cycle after 8th accept.
- Bipolar, same streams -> c=10100101, ones_cnt[0]=4. a_nummax=300, b_nummax=200 -> newnummax=60000.
- in_valid gaps: stream_len=4, in_valid=1,0,0,1,1,0,1 -> exactly 4 accepts, c_valid mirrors accepts delayed 1 cycle, done after 7th input cycle.
- start with stream_len=0 -> done pulse next cycle, ones_cnt=0, busy never asserted. start during RUN -> ignored, counts unaffected.
- rst_n=0 after 3 of 8 accepts -> all outputs 0 next cycle, no done. A new start then runs a clean 8-bit stream.
- With SC_MUL_ISOLATE_EN, a=b=all-ones, stream_len=5 -> ones_cnt=4 (first product uses b_del=0). Without the macro -> ones_cnt=5.

Source files
------------

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types, defaults and product helper for the stochastic multiplier array
//
// Contents:
//   sc_mode_e      : SC_UNIPOLAR (c = a & b) / SC_BIPOLAR (c = ~(a ^ b))
//   sc_mul_state_e : IDLE, RUN, DONE
//   SC_NUMMAX_W    : default nummax field width
//   SC_LEN_W       : default stream-length / ones-counter width
//   sc_product     : one-bit stochastic product for a given mode

package sc_pkg;

    typedef enum logic {
        SC_UNIPOLAR = 1'b0,
        SC_BIPOLAR  = 1'b1
    } sc_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_mul_state_e;

    localparam int SC_NUMMAX_W = 9;
    localparam int SC_LEN_W    = 10;

    function automatic logic sc_product(input sc_mode_e m, input logic a, input logic b);
        return (m == SC_BIPOLAR) ? ~(a ^ b) : (a & b);
    endfunction

endpackage

// File: rtl/sc_mul_lane.sv
// rtl/sc_mul_lane.sv - one stochastic multiplier lane: product gate, c register, ones counter, nummax product
//
// Optional build macro: SC_MUL_ISOLATE_EN (adds a one-accept delay register on the b operand)
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : accepted start; clears the counter (and isolator), latches nummax product
//   accept      : a valid bit pair is consumed this cycle
//   mode        : latched product mode
//   a_nummax    : operand A range
//   b_nummax    : operand B range
//   a_bit/b_bit : operand stream bits
//   c_bit       : registered product bit (holds between accepts)
//   ones_cnt    : number of 1s produced in the current/last run
//   newnummax   : registered a_nummax * b_nummax

module sc_mul_lane
    import sc_pkg::*;
#(
    parameter int W     = SC_NUMMAX_W,
    parameter int LEN_W = SC_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             accept,
    input  sc_mode_e         mode,
    input  logic [W-1:0]     a_nummax,
    input  logic [W-1:0]     b_nummax,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             c_bit,
    output logic [LEN_W-1:0] ones_cnt,
    output logic [2*W-1:0]   newnummax
);

    localparam int PW = 2 * W;

    logic b_eff;
    logic prod;

`ifdef SC_MUL_ISOLATE_EN
    // b is delayed by one accept so a and b of the same cycle are never
    // multiplied together; the run always starts from b_del = 0.
    logic b_del;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_del <= 1'b0;
        end else if (load) begin
            b_del <= 1'b0;
        end else if (accept) begin
            b_del <= b_bit;
        end
    end

    assign b_eff = b_del;
`else
    assign b_eff = b_bit;
`endif

    assign prod = sc_product(mode, a_bit, b_eff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_bit     <= 1'b0;
            ones_cnt  <= '0;
            newnummax <= '0;
        end else if (load) begin
            ones_cnt  <= '0;
            newnummax <= PW'(a_nummax) * PW'(b_nummax);
        end else if (accept) begin
            c_bit    <= prod;
            // Cannot wrap: ones never exceed stream_len <= 2^LEN_W-1.
            ones_cnt <= ones_cnt + LEN_W'(prod);
        end
    end

endmodule

// File: rtl/sc_mul_array.sv
// rtl/sc_mul_array.sv - multi-lane stochastic multiplier with run control and per-lane ones counters
//
// Optional build macro: SC_MUL_ISOLATE_EN (per-lane b-operand isolator, see sc_mul_lane)
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle pulse, honoured in IDLE only
//   stream_len  : bits per lane in the run (sampled on start; 0 completes immediately)
//   mode        : 0 unipolar AND, 1 bipolar XNOR (sampled on start)
//   a_nummax    : per-lane operand A range (sampled on start)
//   b_nummax    : per-lane operand B range (sampled on start)
//   in_valid    : a_bits/b_bits valid this cycle
//   a_bits      : per-lane operand A stream bits
//   b_bits      : per-lane operand B stream bits
//   c_bits      : registered per-lane product bits
//   c_valid     : c_bits updated by the previous cycle's accept
//   newnummax   : per-lane a_nummax * b_nummax
//   ones_cnt    : per-lane count of product 1s
//   busy        : high while running
//   done        : one-cycle pulse after the final accept

module sc_mul_array
    import sc_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = SC_NUMMAX_W,
    parameter int LEN_W = SC_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      stream_len,
    input  logic                  mode,
    input  logic [N_CH*W-1:0]     a_nummax,
    input  logic [N_CH*W-1:0]     b_nummax,
    input  logic                  in_valid,
    input  logic [N_CH-1:0]       a_bits,
    input  logic [N_CH-1:0]       b_bits,
    output logic [N_CH-1:0]       c_bits,
    output logic                  c_valid,
    output logic [N_CH*2*W-1:0]   newnummax,
    output logic [N_CH*LEN_W-1:0] ones_cnt,
    output logic                  busy,
    output logic                  done
);

    sc_mul_state_e    state;
    sc_mul_state_e    next_state;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] len_q;
    sc_mode_e         mode_q;
    logic             load;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (stream_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (bit_cnt == (len_q - LEN_W'(1))) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs are registered from next_state so they line up with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            len_q   <= '0;
            mode_q  <= SC_UNIPOLAR;
            c_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            c_valid <= accept;
            busy    <= (next_state == RUN);
            done    <= (next_state == DONE);
            if (load) begin
                len_q   <= stream_len;
                mode_q  <= sc_mode_e'(mode);
                bit_cnt <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + LEN_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        sc_mul_lane #(
            .W     (W),
            .LEN_W (LEN_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .accept    (accept),
            .mode      (mode_q),
            .a_nummax  (a_nummax[i*W +: W]),
            .b_nummax  (b_nummax[i*W +: W]),
            .a_bit     (a_bits[i]),
            .b_bit     (b_bits[i]),
            .c_bit     (c_bits[i]),
            .ones_cnt  (ones_cnt[i*LEN_W +: LEN_W]),
            .newnummax (newnummax[i*2*W +: 2*W])
        );
    end

endmodule

// File: tb/tb_sc_mul_array.sv
// tb/tb_sc_mul_array.sv - randomized self-checking bench for sc_mul_array against a behavioural model

module tb_sc_mul_array;

    localparam int N_CH  = 4;
    localparam int W     = 9;
    localparam int LEN_W = 10;

`ifdef SC_MUL_ISOLATE_EN
    localparam bit ISO = 1'b1;
`else
    localparam bit ISO = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [LEN_W-1:0]      stream_len = '0;
    logic                  mode = 1'b0;
    logic [N_CH*W-1:0]     a_nummax = '0;
    logic [N_CH*W-1:0]     b_nummax = '0;
    logic                  in_valid = 1'b0;
    logic [N_CH-1:0]       a_bits = '0;
    logic [N_CH-1:0]       b_bits = '0;
    logic [N_CH-1:0]       c_bits;
    logic                  c_valid;
    logic [N_CH*2*W-1:0]   newnummax;
    logic [N_CH*LEN_W-1:0] ones_cnt;
    logic                  busy;
    logic                  done;

    int            checks = 0;
    int            failures = 0;
    logic [N_CH-1:0] last_c = '0;
    int            exp_ones [N_CH];
    longint        exp_nm   [N_CH];

    always #5 clk = ~clk;

    sc_mul_array #(.N_CH(N_CH), .W(W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stream_len (stream_len),
        .mode       (mode),
        .a_nummax   (a_nummax),
        .b_nummax   (b_nummax),
        .in_valid   (in_valid),
        .a_bits     (a_bits),
        .b_bits     (b_bits),
        .c_bits     (c_bits),
        .c_valid    (c_valid),
        .newnummax  (newnummax),
        .ones_cnt   (ones_cnt),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        for (int l = 0; l < N_CH; l++) begin
            chk({tag, "_ones"}, 64'(ones_cnt[l*LEN_W +: LEN_W]), 64'(exp_ones[l]));
            chk({tag, "_nummax"}, 64'(newnummax[l*2*W +: 2*W]), 64'(exp_nm[l]));
        end
    endtask

    // Unipolar: 1 only when both are 1. Bipolar: 1 when the bits agree.
    function automatic logic model_prod(input bit md, input logic a, input logic b);
        if (md) return (a == b);
        return (a && b);
    endfunction

    task automatic drive_noise();
        a_bits     = N_CH'($urandom);
        b_bits     = N_CH'($urandom);
        stream_len = LEN_W'($urandom);
        mode       = 1'($urandom);
    endtask

    task automatic do_run(input int len, input bit md, input int gap_pct, input bit poke,
                          input bit use_pat, input logic [7:0] pa, input logic [7:0] pb);
        logic [N_CH-1:0] bprev;
        logic            bsel;
        logic            acc_now;
        int              acc;
        int              cyc;
        int              av;
        int              bv;
        bprev = '0;
        acc   = 0;
        cyc   = 0;
        for (int l = 0; l < N_CH; l++) begin
            av = $urandom_range(0, 511);
            bv = $urandom_range(0, 511);
            if (use_pat && l == 0) begin
                av = 300;
                bv = 200;
            end
            a_nummax[l*W +: W] = W'(av);
            b_nummax[l*W +: W] = W'(bv);
            exp_nm[l]   = longint'(av) * longint'(bv);
            exp_ones[l] = 0;
        end
        drive_noise();
        start      = 1'b1;
        stream_len = LEN_W'(len);
        mode       = md;
        in_valid   = 1'($urandom);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_c_valid", 64'(c_valid), 0);
        chk("start_c_hold", 64'(c_bits), 64'(last_c));
        chk("start_busy", 64'(busy), 64'(len != 0));
        chk("start_done", 64'(done), 64'(len == 0));
        chk_lanes("start");
        if (use_pat) chk("nummax_300x200", 64'(newnummax[2*W-1:0]), 60000);
        if (len == 0) begin
            @(negedge clk);
            chk("zlen_done_clear", 64'(done), 0);
            chk("zlen_busy", 64'(busy), 0);
            chk_lanes("zlen_hold");
            return;
        end
        while (acc < len && cyc < 4000) begin
            drive_noise();
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            start    = poke ? 1'($urandom) : 1'b0;
            if (use_pat && acc < 8) begin
                a_bits[0] = pa[7-acc];
                b_bits[0] = pb[7-acc];
            end
            acc_now = in_valid;
            if (in_valid) begin
                for (int l = 0; l < N_CH; l++) begin
                    bsel      = ISO ? bprev[l] : b_bits[l];
                    last_c[l] = model_prod(md, a_bits[l], bsel);
                    exp_ones[l] += int'(last_c[l]);
                end
                bprev = b_bits;
                acc++;
            end
            @(negedge clk);
            cyc++;
            chk("c_valid", 64'(c_valid), 64'(acc_now));
            chk("c_bits", 64'(c_bits), 64'(last_c));
            if (acc < len) begin
                chk("run_busy", 64'(busy), 1);
                chk("run_done", 64'(done), 0);
            end else begin
                chk("end_done", 64'(done), 1);
                chk("end_busy", 64'(busy), 0);
                chk_lanes("final");
            end
        end
        if (cyc >= 4000) chk("timeout_accepts", 64'(acc), 64'(len));
        drive_noise();
        start    = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_done", 64'(done), 0);
        chk("post_busy", 64'(busy), 0);
        chk("post_c_valid", 64'(c_valid), 0);
        chk("post_c_hold", 64'(c_bits), 64'(last_c));
        chk_lanes("hold");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_c_bits", 64'(c_bits), 0);
        chk("rst_c_valid", 64'(c_valid), 0);
        chk("rst_nummax", 64'(newnummax), 0);
        chk("rst_ones", 64'(ones_cnt), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_run(8, 1'b0, 0, 1'b0, 1'b1, 8'hF0, 8'hAA);
        do_run(8, 1'b1, 0, 1'b0, 1'b1, 8'hF0, 8'hAA);
        do_run(4, 1'b0, 45, 1'b0, 1'b0, 8'h00, 8'h00);
        do_run(0, 1'b1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_run(12, 1'b1, 30, 1'b1, 1'b0, 8'h00, 8'h00);
        do_run(5, 1'b0, 0, 1'b0, 1'b1, 8'hFF, 8'hFF);

        // Abort a run after three accepts.
        start      = 1'b1;
        stream_len = LEN_W'(8);
        a_nummax   = N_CH*W'($urandom);
        b_nummax   = N_CH*W'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            drive_noise();
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_c_bits", 64'(c_bits), 0);
        chk("abort_c_valid", 64'(c_valid), 0);
        chk("abort_nummax", 64'(newnummax), 0);
        chk("abort_ones", 64'(ones_cnt), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        @(negedge clk);
        chk("abort_no_done", 64'(done), 0);
        last_c = '0;
        do_run(8, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00);

        for (int k = 0; k < 20; k++) begin
            do_run($urandom_range(1, 40), 1'($urandom), $urandom_range(0, 60),
                   1'($urandom), 1'b0, 8'h00, 8'h00);
        end
        do_run(1023, 1'b1, 0, 1'b1, 1'b0, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
